// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types for the RGB fade sequencer: FSM state encoding, colour struct and palette.
package rgb_fade_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FADE  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t palette(input logic [2:0] idx);
    rgb_t c;
    c = 24'h000000;
    case (idx)
      3'd0: c = 24'hFF0000;
      3'd1: c = 24'hFF4000;
      3'd2: c = 24'hFFC000;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'h00FFFF;
      3'd5: c = 24'h0000FF;
      3'd6: c = 24'h8000FF;
      3'd7: c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_debounce.sv
// Front-panel key conditioner: two-flop synchroniser, stability counter, one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          accept;

  // A new level is accepted once it has differed from the stored one for DEB_CYCLES samples.
  assign accept = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= accept && !sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Palette cross-fade sequencer feeding the LED strip PWM duty bytes, with next/pause keys.
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 46875,
  parameter int STEPS      = 64,
  parameter int HOLD_TICKS = 256,
  parameter int DEB_CYCLES = 120000
) (
  input  logic       clk12MHz,
  input  logic       reset,
  input  logic       key_next,
  input  logic       key_pause,
  output logic [7:0] RedPWM,
  output logic [7:0] GreenPWM,
  output logic [7:0] BluePWM,
  output logic [2:0] colour_idx,
  output logic       fading,
  output logic       paused
);

  localparam int LOG2_STEPS = $clog2(STEPS);
  localparam int SW         = LOG2_STEPS + 1;
  localparam int MW         = 9 + LOG2_STEPS;
  localparam int TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW         = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [SW-1:0] STEPS_V = SW'(STEPS);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          next_p, pause_p;
  logic          next_ev, pause_ev;

  state_t        state, state_nx, saved, saved_nx;
  logic [SW-1:0] step, step_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [2:0]    idx, idx_nx;
  rgb_t          start, start_nx, target, target_nx, duty, duty_nx, mix_rgb, snap;
  logic          pend_next, pend_next_nx, pend_pause, pend_pause_nx;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk12MHz), .reset(reset), .key(key_next), .press(next_p)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk(clk12MHz), .reset(reset), .key(key_pause), .press(pause_p)
  );

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  function automatic logic [7:0] mix8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [SW-1:0] s);
    logic [MW-1:0] acc;
    acc = MW'(a) * MW'(STEPS_V - s) + MW'(b) * MW'(s);
    return 8'(acc >> LOG2_STEPS);
  endfunction

  always_comb begin
    mix_rgb.r = mix8(start.r, target.r, step);
    mix_rgb.g = mix8(start.g, target.g, step);
    mix_rgb.b = mix8(start.b, target.b, step);
  end

  assign snap     = palette(idx + 3'd1);
  // Key pulses that land in LOAD are replayed on the following FADE cycle.
  assign next_ev  = next_p | pend_next;
  assign pause_ev = pause_p | pend_pause;

  always_comb begin
    state_nx      = state;
    saved_nx      = saved;
    step_nx       = step;
    hold_nx       = hold;
    idx_nx        = idx;
    start_nx      = start;
    target_nx     = target;
    duty_nx       = duty;
    pend_next_nx  = 1'b0;
    pend_pause_nx = 1'b0;
    case (state)
      ST_LOAD: begin
        target_nx     = palette(idx);
        step_nx       = '0;
        state_nx      = ST_FADE;
        pend_next_nx  = next_p;
        pend_pause_nx = pause_p;
      end
      ST_FADE: begin
        if (pause_ev) begin
          saved_nx = ST_FADE;
          state_nx = ST_PAUSE;
        end else if (next_ev) begin
          start_nx = duty;
          idx_nx   = idx + 3'd1;
          state_nx = ST_LOAD;
        end else begin
          duty_nx = mix_rgb;
          if (tick) begin
            step_nx = step + 1'b1;
            if (step == STEPS_V - 1'b1) begin
              hold_nx  = '0;
              state_nx = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (pause_ev) begin
          saved_nx = ST_HOLD;
          state_nx = ST_PAUSE;
        end else if (next_ev) begin
          start_nx = duty;
          idx_nx   = idx + 3'd1;
          state_nx = ST_LOAD;
        end else begin
          duty_nx = mix_rgb;
          if (tick) begin
            if (hold == HW'(HOLD_TICKS - 1)) begin
              start_nx = target;
              idx_nx   = idx + 3'd1;
              state_nx = ST_LOAD;
            end else begin
              hold_nx = hold + 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (pause_p) begin
          state_nx = saved;
        end else if (next_p) begin
          // Snap straight to the next colour and resume later as if it had just been reached.
          idx_nx    = idx + 3'd1;
          start_nx  = snap;
          target_nx = snap;
          duty_nx   = snap;
          step_nx   = STEPS_V;
          hold_nx   = '0;
          saved_nx  = ST_HOLD;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      tick_cnt   <= '0;
      state      <= ST_LOAD;
      saved      <= ST_FADE;
      step       <= '0;
      hold       <= '0;
      idx        <= '0;
      start      <= '0;
      target     <= '0;
      duty       <= '0;
      pend_next  <= 1'b0;
      pend_pause <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      state      <= state_nx;
      saved      <= saved_nx;
      step       <= step_nx;
      hold       <= hold_nx;
      idx        <= idx_nx;
      start      <= start_nx;
      target     <= target_nx;
      duty       <= duty_nx;
      pend_next  <= pend_next_nx;
      pend_pause <= pend_pause_nx;
    end
  end

  assign RedPWM     = duty.r;
  assign GreenPWM   = duty.g;
  assign BluePWM    = duty.b;
  assign colour_idx = idx;
  assign fading     = (state == ST_FADE);
  assign paused     = (state == ST_PAUSE);

endmodule
